axi4_lite_rd_demux: RTL and testbench

AXI4_LITE_RD_DEMUX -- requirements
Module: axi4_lite_rd_demux

---
 rtl/axi4_lite_rd_demux.sv | 153 +++++++++++++++
 tb/tb_axi4_lite_rd_demux.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_rd_demux.sv
// axi4_lite_rd_demux
// Routes AXI4-Lite read transactions from one upstream manager to N
// downstream read ports by address decode. Reads that decode to no port go
// to an internal error target that answers with DECERR and zero data.
// Responses are returned strictly in request order: a read to a different
// target waits until every outstanding response has come back.
//
// Ports
//   aclk, aresetn            clock, asynchronous active-low reset
//   s_araddr/arprot/arvalid  upstream read address channel (s_arready out)
//   s_rdata/rresp/rvalid     upstream read data channel (s_rready in)
//   m_araddr/arprot          downstream address, broadcast to every slice
//   m_arvalid/arready        downstream address handshake, one bit per port
//   m_rdata/rresp/rvalid     downstream read data, slice j belongs to port j
//   m_rready                 downstream read ready, one bit per port
//
// Handshakes: every channel transfers on a rising aclk edge where valid and
// ready are both high; a raised valid holds, with stable payload, until that
// transfer happens.
module axi4_lite_rd_demux #(
  parameter int N       = 2,
  parameter int A       = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 4,
  parameter logic [N-1:0][A-1:0] BASE = '0,
  parameter logic [N-1:0][A-1:0] MASK = '0
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [A-1:0]    s_araddr,
  input  logic [2:0]      s_arprot,
  input  logic            s_arvalid,
  output logic            s_arready,
  output logic [DW-1:0]   s_rdata,
  output logic [1:0]      s_rresp,
  output logic            s_rvalid,
  input  logic            s_rready,
  output logic [N*A-1:0]  m_araddr,
  output logic [N*3-1:0]  m_arprot,
  output logic [N-1:0]    m_arvalid,
  input  logic [N-1:0]    m_arready,
  input  logic [N*DW-1:0] m_rdata,
  input  logic [N*2-1:0]  m_rresp,
  input  logic [N-1:0]    m_rvalid,
  output logic [N-1:0]    m_rready
);

  localparam int TW = $clog2(N + 1);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [TW-1:0] TGT_E   = TW'(N);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

  // run is low during reset and rises on the first aclk edge after release,
  // so the upstream channel opens cleanly in step with the clock.
  logic          run;
  logic          ar_full;
  logic [A-1:0]  ar_addr;
  logic [2:0]    ar_prot;
  logic [TW-1:0] ar_tgt;
  logic [TW-1:0] cur;
  logic [CW-1:0] count;

  logic [TW-1:0] dec_tgt;
  logic          tgt_ready;
  logic          issue;
  logic          ar_fire;
  logic          r_fire;

  // Address decode: walk from the highest port down so the lowest match wins.
  always_comb begin
    dec_tgt = TGT_E;
    for (int j = N - 1; j >= 0; j--) begin
      if ((s_araddr & MASK[j]) == (BASE[j] & MASK[j])) dec_tgt = TW'(j);
    end
  end

  // The error target accepts its address unconditionally.
  always_comb begin
    tgt_ready = (ar_tgt == TGT_E);
    for (int j = 0; j < N; j++) begin
      if (ar_tgt == TW'(j)) tgt_ready = m_arready[j];
    end
  end

  // A held address may only issue to the target that already owns the
  // outstanding responses, or to anyone once nothing is outstanding.
  assign issue     = ar_full & (count < CNT_MAX) & ((count == '0) | (ar_tgt == cur));
  assign ar_fire   = issue & tgt_ready;
  assign s_arready = run & (~ar_full | ar_fire);
  assign r_fire    = s_rvalid & s_rready;

  always_comb begin
    m_arvalid = '0;
    for (int j = 0; j < N; j++) begin
      m_arvalid[j] = issue & (ar_tgt == TW'(j));
    end
    m_araddr = {N{ar_addr}};
    m_arprot = {N{ar_prot}};
  end

  // Response path follows cur, which is frozen while count != 0, so the
  // upstream response cannot change under a stalled s_rready.
  always_comb begin
    s_rvalid = 1'b0;
    s_rdata  = '0;
    s_rresp  = '0;
    m_rready = '0;
    if (run) begin
      if (cur == TGT_E) begin
        s_rvalid = (count != '0);
        if (count != '0) s_rresp = 2'b11;
      end else begin
        for (int j = 0; j < N; j++) begin
          if (cur == TW'(j)) begin
            s_rvalid    = m_rvalid[j] & (count != '0);
            s_rdata     = m_rdata[j*DW +: DW];
            s_rresp     = m_rresp[j*2 +: 2];
            m_rready[j] = s_rready;
          end
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run     <= 1'b0;
      ar_full <= 1'b0;
      ar_addr <= '0;
      ar_prot <= '0;
      ar_tgt  <= '0;
      cur     <= '0;
      count   <= '0;
    end else begin
      run <= 1'b1;
      if (s_arvalid && s_arready) begin
        ar_full <= 1'b1;
        ar_addr <= s_araddr;
        ar_prot <= s_arprot;
        ar_tgt  <= dec_tgt;
      end else if (ar_fire) begin
        ar_full <= 1'b0;
      end
      if (ar_fire) cur <= ar_tgt;
      case ({ar_fire, r_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_rd_demux.sv
// Bench for axi4_lite_rd_demux with two ports at 0x0000 and 0x1000 (mask
// 0xF000). Downstream ports are modelled as simple in-order slaves whose read
// data is addr ^ 0xA5A1 and whose response is SLVERR when addr[3:2] == 3.
`timescale 1ns/1ps
module tb_axi4_lite_rd_demux;
  localparam int N = 2, A = 32, DW = 32, MAX_OUT = 4;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] s_araddr = '0;
  logic [2:0]  s_arprot = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b0;
  logic [63:0] m_araddr;
  logic [5:0]  m_arprot;
  logic [1:0]  m_arvalid;
  logic [1:0]  m_arready = '0;
  logic [63:0] m_rdata = '0;
  logic [3:0]  m_rresp = '0;
  logic [1:0]  m_rvalid = '0;
  logic [1:0]  m_rready;

  axi4_lite_rd_demux #(
    .N(N), .A(A), .DW(DW), .MAX_OUT(MAX_OUT),
    .BASE({32'h0000_1000, 32'h0000_0000}),
    .MASK({32'h0000_F000, 32'h0000_F000})
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  // clock / watchdog
  always #5 aclk = ~aclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // bench state
  int total = 0, bad = 0, cyc = 0;
  logic [31:0] req_q[$];
  logic [31:0] sq0[$], sq1[$];
  logic [33:0] exp_q[$];
  int  ar_rdy_pct[2];
  int  r_pct, s_rready_pct, s_arvalid_pct;
  bit  r_en;
  int  acc[2];
  bit  found;
  logic       ar_hs, r_hs;
  logic [1:0] m_ar_hs, m_r_hs;
  logic [31:0] smp_maddr;
  bit          have_prev = 0;
  logic [1:0]  prev_marv, prev_marhs;
  logic [31:0] prev_maddr, prev_rd;
  logic        prev_srv, prev_rhs;
  logic [1:0]  prev_rr;

  typedef struct {
    logic [31:0] addr;
    int          tgt;   // 0, 1, or 2 for the error target
    logic [31:0] data;
    logic [1:0]  resp;
  } vec_t;
  vec_t vec[9];

  // reference model
  function automatic int model_port(logic [31:0] a);
    if ((a & 32'h0000_F000) == 32'h0000_0000) return 0;
    if ((a & 32'h0000_F000) == 32'h0000_1000) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] data_of(logic [31:0] a);
    return a ^ 32'h0000_A5A1;
  endfunction

  function automatic logic [1:0] resp_of(logic [31:0] a);
    return (a[3:2] == 2'b11) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [33:0] model_resp(logic [31:0] a);
    if (model_port(a) == 2) return {2'b11, 32'h0};
    return {resp_of(a), data_of(a)};
  endfunction

  function automatic bit pct(int p);
    return int'($urandom_range(0, 99)) < p;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom();
    case ($urandom_range(0, 3))
      0:       a[15:12] = 4'h0;
      1, 2:    a[15:12] = 4'h1;
      default: a[15:12] = a[15:12];
    endcase
    return a;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic set_directed();
    ar_rdy_pct[0] = 100; ar_rdy_pct[1] = 100;
    r_pct = 100; s_rready_pct = 100; s_arvalid_pct = 100; r_en = 1;
  endtask

  // Sample on the falling edge: these are the transfers the next rising edge commits.
  task automatic sample();
    logic [33:0] e;
    @(negedge aclk);
    cyc++;
    ar_hs     = s_arvalid & s_arready;
    r_hs      = s_rvalid & s_rready;
    m_ar_hs   = m_arvalid & m_arready;
    m_r_hs    = m_rvalid & m_rready;
    smp_maddr = m_araddr[31:0];
    if (m_ar_hs[0]) acc[0]++;
    if (m_ar_hs[1]) acc[1]++;
    // scoreboard
    if (r_hs) begin
      check("r_has_expect", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("r_data", s_rdata, e[31:0]);
        check("r_resp", s_rresp, e[33:32]);
      end
    end
    if (ar_hs) exp_q.push_back(model_resp(s_araddr));
    // protocol and ordering rules
    if (m_arvalid != 0)
      check("m_arvalid_route", m_arvalid, 64'(1) << model_port(m_araddr[31:0]));
    if (have_prev && prev_marv != 0 && (prev_marv & prev_marhs) == 0) begin
      check("m_arvalid_hold", m_arvalid, prev_marv);
      check("m_araddr_hold", m_araddr[31:0], prev_maddr);
    end
    if (have_prev && prev_srv && !prev_rhs) begin
      check("s_rvalid_hold", s_rvalid, 1);
      check("s_rdata_hold", s_rdata, prev_rd);
      check("s_rresp_hold", s_rresp, prev_rr);
    end
    check("ds_outstanding_le_max", (sq0.size() + sq1.size()) <= MAX_OUT, 1);
    check("ds_single_target", (sq0.size() > 0) && (sq1.size() > 0), 0);
    if (sq0.size() > 0) check("m_rready_p0", m_rready, {1'b0, s_rready});
    else if (sq1.size() > 0) check("m_rready_p1", m_rready, {s_rready, 1'b0});
    have_prev  = aresetn;
    prev_marv  = m_arvalid;
    prev_marhs = m_ar_hs;
    prev_maddr = m_araddr[31:0];
    prev_srv   = s_rvalid;
    prev_rhs   = r_hs;
    prev_rd    = s_rdata;
    prev_rr    = s_rresp;
  endtask

  task automatic update();
    @(posedge aclk);
    #1;
    if (ar_hs) void'(req_q.pop_front());
    if (m_ar_hs[0]) sq0.push_back(smp_maddr);
    if (m_ar_hs[1]) sq1.push_back(smp_maddr);
    if (m_r_hs[0]) begin void'(sq0.pop_front()); m_rvalid[0] = 1'b0; end
    if (m_r_hs[1]) begin void'(sq1.pop_front()); m_rvalid[1] = 1'b0; end
    if (!m_rvalid[0]) m_rdata[31:0] = $urandom();
    if (!m_rvalid[1]) m_rdata[63:32] = $urandom();
    if (!m_rvalid[0] && sq0.size() > 0 && r_en && pct(r_pct)) begin
      m_rvalid[0] = 1'b1; m_rdata[31:0] = data_of(sq0[0]); m_rresp[1:0] = resp_of(sq0[0]);
    end
    if (!m_rvalid[1] && sq1.size() > 0 && r_en && pct(r_pct)) begin
      m_rvalid[1] = 1'b1; m_rdata[63:32] = data_of(sq1[0]); m_rresp[3:2] = resp_of(sq1[0]);
    end
    m_arready[0] = pct(ar_rdy_pct[0]);
    m_arready[1] = pct(ar_rdy_pct[1]);
    s_rready = pct(s_rready_pct);
    if (!s_arvalid || ar_hs) begin
      s_arvalid = (req_q.size() > 0) && pct(s_arvalid_pct);
      if (req_q.size() > 0) begin
        s_araddr = req_q[0];
        s_arprot = 3'($urandom_range(0, 7));
      end
    end
    ar_hs = 0; r_hs = 0; m_ar_hs = '0; m_r_hs = '0;
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) begin sample(); update(); end
  endtask

  task automatic drain(int max);
    bit done;
    done = 0;
    set_directed();
    for (int k = 0; k < max && !done; k++) begin
      sample();
      if (req_q.size() == 0 && exp_q.size() == 0 && sq0.size() == 0 && sq1.size() == 0 && !s_arvalid)
        done = 1;
      update();
    end
    check("drain_complete", done, 1);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_s_arready"}, s_arready, 0);
    check({tag, "_s_rvalid"}, s_rvalid, 0);
    check({tag, "_m_arvalid"}, m_arvalid, 0);
    check({tag, "_m_rready"}, m_rready, 0);
    check({tag, "_s_rdata"}, s_rdata, 0);
    check({tag, "_s_rresp"}, s_rresp, 0);
  endtask

  task automatic clear_bench();
    req_q.delete(); sq0.delete(); sq1.delete(); exp_q.delete();
    s_arvalid = 0; s_rready = 0; m_rvalid = '0; m_arready = '0;
    ar_hs = 0; r_hs = 0; m_ar_hs = '0; m_r_hs = '0;
    have_prev = 0;
  endtask

  task automatic release_reset();
    @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    check("arready_before_sync", s_arready, 0);
    @(negedge aclk);
    check("arready_after_sync", s_arready, 1);
  endtask

  // test sequence
  initial begin
    int hs_cyc, mv_cyc;
    logic [1:0] seen;
    logic [33:0] got;
    bit got_r;

    vec[0] = '{32'h0000_0004, 0, 32'h0000_A5A5, 2'b00};
    vec[1] = '{32'h0000_1000, 1, 32'h0000_B5A1, 2'b00};
    vec[2] = '{32'h0000_0FFC, 0, 32'h0000_AA5D, 2'b10};
    vec[3] = '{32'h0000_1FFC, 1, 32'h0000_BA5D, 2'b10};
    vec[4] = '{32'h0000_8000, 2, 32'h0000_0000, 2'b11};
    vec[5] = '{32'h0000_2000, 2, 32'h0000_0000, 2'b11};
    vec[6] = '{32'hFFFF_0008, 0, 32'hFFFF_A5A9, 2'b00};
    vec[7] = '{32'hABCD_1234, 1, 32'hABCD_B795, 2'b00};
    vec[8] = '{32'hABCD_5234, 2, 32'h0000_0000, 2'b11};
    acc = '{0, 0};
    set_directed();

    // reset with busy-looking inputs
    aresetn = 1'b0;
    s_arvalid = 1'b1; s_araddr = 32'h4; s_rready = 1'b1;
    m_rvalid = 2'b11; m_arready = 2'b11; m_rdata = 64'h1234_5678_9ABC_DEF0; m_rresp = 4'b1111;
    repeat (3) @(posedge aclk);
    #1;
    check_reset_outputs("rst");
    clear_bench();
    release_reset();

    // table-driven single reads
    for (int i = 0; i < 9; i++) begin
      set_directed();
      req_q.push_back(vec[i].addr);
      hs_cyc = -1; mv_cyc = -1; seen = '0; got = '0; got_r = 0;
      for (int k = 0; k < 40 && !got_r; k++) begin
        sample();
        if (m_arvalid != 0 && mv_cyc < 0) mv_cyc = cyc;
        seen |= m_arvalid;
        if (ar_hs) hs_cyc = cyc;
        if (r_hs) begin got_r = 1; got = {s_rresp, s_rdata}; end
        update();
      end
      check("vec_got_response", got_r, 1);
      check("vec_target", seen, (vec[i].tgt < 2) ? (2'b01 << vec[i].tgt) : 2'b00);
      if (vec[i].tgt < 2) check("vec_ar_latency", 64'(mv_cyc - hs_cyc), 1);
      check("vec_rdata", got[31:0], vec[i].data);
      check("vec_rresp", got[33:32], vec[i].resp);
      run(2);
    end
    check("count_idle", dut.count, 0);

    // outstanding limit: fifth read stalls, one response frees one slot
    set_directed(); r_en = 0; acc = '{0, 0};
    for (int i = 0; i < 5; i++) req_q.push_back(32'h1000 + 32'(4 * i));
    run(15);
    check("ostd_accepted", acc[1], 4);
    sample();
    check("ostd_fifth_stalled", m_arvalid, 0);
    check("ostd_arready_low", s_arready, 0);
    check("ostd_count", dut.count, 4);
    r_en = 1;
    update();
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      sample();
      if (m_r_hs[1]) begin found = 1; r_en = 0; end
      update();
    end
    check("ostd_one_resp", found, 1);
    sample();
    check("ostd_slot_reissue", m_arvalid, 2'b10);
    update();
    drain(100);

    // target switch waits for outstanding responses
    set_directed(); r_en = 0; acc = '{0, 0};
    req_q.push_back(32'h0000_0000); req_q.push_back(32'h0000_1000);
    run(10);
    check("order_p0_issued", acc[0], 1);
    check("order_p1_held", acc[1], 0);
    sample();
    check("order_p1_not_valid", m_arvalid, 0);
    update();
    drain(50);
    check("order_p1_issued_after", acc[1], 1);

    // unmapped address: DECERR held while s_rready is low
    set_directed(); s_rready_pct = 0; acc = '{0, 0};
    req_q.push_back(32'h0000_8000);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      sample();
      if (s_rvalid) found = 1;
      update();
    end
    check("err_rvalid_seen", found, 1);
    for (int k = 0; k < 3; k++) begin
      sample();
      check("err_hold_rvalid", s_rvalid, 1);
      check("err_hold_rresp", s_rresp, 2'b11);
      check("err_hold_rdata", s_rdata, 0);
      update();
    end
    drain(50);
    check("err_no_downstream_ar", acc[0] + acc[1], 0);

    // simultaneous address issue and response at count 2
    set_directed(); r_en = 0; acc = '{0, 0};
    req_q.push_back(32'h0000_0010); req_q.push_back(32'h0000_0014);
    run(8);
    check("sim_two_out", acc[0], 2);
    ar_rdy_pct[0] = 0;
    req_q.push_back(32'h0000_0018);
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      sample();
      if (m_arvalid[0]) begin found = 1; ar_rdy_pct[0] = 100; r_en = 1; end
      update();
    end
    check("sim_third_valid", found, 1);
    sample();
    check("sim_both_fire", {m_ar_hs[0], m_r_hs[0]}, 2'b11);
    r_en = 0;
    update();
    sample();
    check("sim_count_stays", dut.count, 2);
    update();
    drain(50);

    // reset in the middle of a burst
    set_directed(); r_en = 0; acc = '{0, 0};
    req_q.push_back(32'h1100); req_q.push_back(32'h1104); req_q.push_back(32'h1108);
    run(10);
    check("rst_mid_accepted", acc[1], 3);
    check("rst_mid_count", dut.count, 3);
    #2 aresetn = 1'b0;
    #1;
    clear_bench();
    m_rvalid = 2'b11; s_rready = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    check("rst_mid_count_clr", dut.count, 0);
    m_rvalid = '0; s_rready = 1'b0;
    repeat (2) @(posedge aclk);
    release_reset();
    set_directed();
    req_q.push_back(32'h0000_0004);
    drain(50);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if (k % 250 == 0) begin
        ar_rdy_pct[0] = $urandom_range(10, 100);
        ar_rdy_pct[1] = $urandom_range(10, 100);
        r_pct         = $urandom_range(10, 100);
        s_rready_pct  = $urandom_range(10, 100);
        s_arvalid_pct = $urandom_range(20, 100);
        r_en          = 1;
      end
      if (req_q.size() < 3 && pct(40)) req_q.push_back(rand_addr());
      sample();
      update();
    end
    drain(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
